// File: rtl/fetch_unit.sv
// Instruction fetch sequencer: reads one- or two-byte instructions through the
// program counter, then holds each one on a valid/ready issue handshake.
module fetch_unit #(
  parameter int WORD_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [WORD_WIDTH-1:0] pc,
  output logic                  mem_read,
  output logic [WORD_WIDTH-1:0] mem_address,
  input  logic [WORD_WIDTH-1:0] mem_data,
  input  logic                  mem_ready,
  output logic                  pc_enable,
  output logic                  jump,
  output logic                  jz,
  output logic [WORD_WIDTH-1:0] jump_address,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [3:0]            opcode,
  output logic [3:0]            reg_sel,
  output logic [WORD_WIDTH-1:0] operand,
  output logic                  halted
);

  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_JZ   = 4'h9;
  localparam logic [3:0] OP_LDI  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [1:0] {
    FETCH_OP,
    FETCH_ARG,
    ISSUE,
    HALT
  } state_t;

  state_t state, state_next;

  function automatic logic is_two_byte(input logic [3:0] op);
    return (op == OP_JMP) || (op == OP_JZ) || (op == OP_LDI);
  endfunction

  assign mem_address = pc;

  // Operand is cleared when a new opcode lands so one-byte instructions issue with 0;
  // jump_address only follows real second bytes, so it keeps the last operand.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= FETCH_OP;
      opcode       <= '0;
      reg_sel      <= '0;
      operand      <= '0;
      jump_address <= '0;
    end else begin
      state <= state_next;
      if (state == FETCH_OP && mem_ready) begin
        opcode  <= mem_data[7:4];
        reg_sel <= mem_data[3:0];
        operand <= '0;
      end
      if (state == FETCH_ARG && mem_ready) begin
        operand      <= mem_data;
        jump_address <= mem_data;
      end
    end
  end

  always_comb begin
    state_next  = state;
    mem_read    = 1'b0;
    pc_enable   = 1'b0;
    jump        = 1'b0;
    jz          = 1'b0;
    instr_valid = 1'b0;
    halted      = 1'b0;
    case (state)
      FETCH_OP: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_enable  = 1'b1;
          state_next = is_two_byte(mem_data[7:4]) ? FETCH_ARG : ISSUE;
        end
      end
      FETCH_ARG: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          pc_enable  = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        instr_valid = 1'b1;
        if (instr_ready) begin
          state_next = (opcode == OP_HALT) ? HALT : FETCH_OP;
          if (opcode == OP_JMP) begin
            pc_enable = 1'b1;
            jump      = 1'b1;
          end
          if (opcode == OP_JZ) begin
            pc_enable = 1'b1;
            jz        = 1'b1;
          end
        end
      end
      HALT: begin
        halted = 1'b1;
      end
      default: begin
        state_next = FETCH_OP;
      end
    endcase
    // A fetch or transfer caught by reset must not move the program counter.
    if (reset) begin
      pc_enable   = 1'b0;
      jump        = 1'b0;
      jz          = 1'b0;
      instr_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: models program_counter and instruction memory, predicts
// the fetch/issue stream by walking the program, and pins key cases by hand.
module tb_fetch_unit;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] pc = '0;
  logic       mem_read;
  logic [7:0] mem_address;
  logic [7:0] mem_data = '0;
  logic       mem_ready = 1'b0;
  logic       pc_enable;
  logic       jump;
  logic       jz;
  logic [7:0] jump_address;
  logic       instr_valid;
  logic       instr_ready = 1'b0;
  logic [3:0] opcode;
  logic [3:0] reg_sel;
  logic [7:0] operand;
  logic       halted;

  fetch_unit #(.WORD_WIDTH(8)) dut (
    .clock(clock),
    .reset(reset),
    .pc(pc),
    .mem_read(mem_read),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_ready(mem_ready),
    .pc_enable(pc_enable),
    .jump(jump),
    .jz(jz),
    .jump_address(jump_address),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .opcode(opcode),
    .reg_sel(reg_sel),
    .operand(operand),
    .halted(halted)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] addr;
    bit         is_arg;
  } fetch_t;

  typedef struct {
    logic [3:0] op;
    logic [3:0] rs;
    logic [7:0] opd;
  } issue_t;

  logic [7:0] mem [0:255];
  fetch_t     fetch_q [$];
  issue_t     issue_q [$];
  bit         zero_flag = 1'b0;
  int         mem_stall = 0;
  int         ir_stall = 0;
  int         mwait = 0;
  int         iwait = 0;
  int         checks = 0;
  int         failures = 0;

  int         cyc = 0;
  int         pe_count = 0;
  int         halt_cycles = 0;
  int         issue_cycles [$];
  logic [15:0] first_issue = '0;
  bit         have_first = 1'b0;
  logic [7:0] jump_addr_seen = '0;
  logic [7:0] next_fetch = '0;
  bit         await_fetch = 1'b0;
  logic [7:0] last_operand = '0;
  bit         prev_hold = 1'b0;
  bit         prev_reset = 1'b1;
  logic [15:0] prev_word = '0;
  logic [15:0] cur = '0;
  bit         load_operand = 1'b0;
  logic [7:0] new_operand = '0;
  fetch_t     f;
  issue_t     e;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  function automatic int issue_cycle(input int k);
    return (issue_cycles.size() > k) ? issue_cycles[k] : -1;
  endfunction

  // Walk the program as the architecture defines it to get the fetch and issue streams.
  task automatic build_model();
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opd;
    logic [7:0] nxt;
    logic [3:0] op;
    fetch_q.delete();
    issue_q.delete();
    a = 8'h00;
    for (int n = 0; n < 64; n++) begin
      b  = mem[a];
      op = b[7:4];
      fetch_q.push_back('{addr: a, is_arg: 1'b0});
      if (op == 4'h8 || op == 4'h9 || op == 4'hA) begin
        fetch_q.push_back('{addr: a + 8'd1, is_arg: 1'b1});
        opd = mem[a + 8'd1];
        nxt = a + 8'd2;
      end else begin
        opd = 8'h00;
        nxt = a + 8'd1;
      end
      issue_q.push_back('{op: op, rs: b[3:0], opd: opd});
      if (op == 4'hF) break;
      if (op == 4'h8 || (op == 4'h9 && zero_flag)) nxt = opd;
      a = nxt;
    end
  endtask

  task automatic drive_inputs();
    if (mem_read) begin
      if (mwait < mem_stall) begin
        mem_ready = 1'b0;
        mwait++;
      end else begin
        mem_ready = 1'b1;
        mwait = 0;
      end
    end else begin
      mem_ready = 1'($urandom_range(0, 1));
    end
    mem_data = (mem_read && mem_ready) ? mem[pc] : 8'($urandom);
    if (instr_valid) begin
      if (iwait < ir_stall) begin
        instr_ready = 1'b0;
        iwait++;
      end else begin
        instr_ready = 1'b1;
        iwait = 0;
      end
    end else begin
      instr_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // program_counter model: jump loads, jz loads only on zero, otherwise increment.
  task automatic applyStimulus(input int n);
    logic pe, jp, jzz, rs;
    logic [7:0] ja;
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      pe  = pc_enable;
      jp  = jump;
      jzz = jz;
      ja  = jump_address;
      rs  = reset;
      @(posedge clock);
      #1;
      if (rs) pc = 8'h00;
      else if (pe) begin
        if (jp || (jzz && zero_flag)) pc = ja;
        else if (!jzz) pc = pc + 8'd1;
      end
      drive_inputs();
    end
  endtask

  task automatic start_test();
    reset = 1'b1;
    build_model();
    applyStimulus(2);
    reset = 1'b0;
    mwait = 0;
    iwait = 0;
    drive_inputs();
  endtask

  task automatic load_prog(input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [7:0] b3);
    for (int i = 0; i < 256; i++) mem[i] = 8'hF0;
    mem[0] = b0;
    mem[1] = b1;
    mem[2] = b2;
    mem[3] = b3;
  endtask

  task automatic end_test(input string name);
    checkOutput({name, "_drain"}, fetch_q.size() + issue_q.size(), 0);
    checkOutput({name, "_halted"}, halted, 1);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      checkOutput("reset_strobes", {pc_enable, jump, jz}, 3'b000);
      cyc = 0;
      pe_count = 0;
      issue_cycles.delete();
      have_first = 1'b0;
      await_fetch = 1'b0;
      next_fetch = 8'hEE;
      jump_addr_seen = 8'hEE;
      last_operand = 8'h00;
      prev_hold = 1'b0;
      prev_reset = 1'b1;
    end else begin
      cyc++;
      if (prev_reset)
        checkOutput("reset_state",
                    {mem_read, instr_valid, halted, jump_address, opcode, reg_sel, operand},
                    {1'b1, 26'd0});
      prev_reset = 1'b0;
      if (pc_enable) pe_count++;
      if (halted && !mem_read) halt_cycles++;
      checkOutput("jump_address_hold", jump_address, last_operand);
      load_operand = 1'b0;
      if (mem_read) begin
        checkOutput("mem_address", mem_address, pc);
        if (mem_ready) begin
          checkOutput("fetch_accept", {halted, instr_valid, pc_enable, jump, jz}, 5'b00100);
          if (fetch_q.size() == 0) checkOutput("fetch_extra", 1, 0);
          else begin
            f = fetch_q.pop_front();
            checkOutput("fetch_addr", pc, f.addr);
            if (f.is_arg) begin
              load_operand = 1'b1;
              new_operand = mem[f.addr];
            end
          end
          if (await_fetch) begin
            next_fetch = pc;
            await_fetch = 1'b0;
          end
        end else begin
          checkOutput("fetch_stall", {halted, instr_valid, pc_enable, jump, jz}, 5'b00000);
        end
      end else if (instr_valid) begin
        cur = {opcode, reg_sel, operand};
        if (prev_hold) checkOutput("issue_stable", cur, prev_word);
        if (instr_ready) begin
          issue_cycles.push_back(cyc);
          if (!have_first) begin
            first_issue = cur;
            have_first = 1'b1;
          end
          if (issue_q.size() == 0) checkOutput("issue_extra", 1, 0);
          else begin
            e = issue_q.pop_front();
            checkOutput("issue_word", cur, {e.op, e.rs, e.opd});
            checkOutput("issue_ctrl", {halted, pc_enable, jump, jz},
                        {1'b0, (e.op == 4'h8 || e.op == 4'h9), e.op == 4'h8, e.op == 4'h9});
            if (e.op == 4'h8 || e.op == 4'h9) begin
              checkOutput("issue_target", jump_address, e.opd);
              jump_addr_seen = jump_address;
              await_fetch = 1'b1;
            end
          end
          prev_hold = 1'b0;
        end else begin
          checkOutput("issue_wait", {halted, pc_enable, jump, jz}, 4'b0000);
          prev_hold = 1'b1;
          prev_word = cur;
        end
      end else begin
        checkOutput("halt_state", {halted, pc_enable, jump, jz}, 4'b1000);
      end
      if (load_operand) last_operand = new_operand;
    end
  end

  initial begin
    $display("[TB] one-byte pair");
    load_prog(8'h13, 8'h25, 8'hF0, 8'hF0);
    zero_flag = 1'b0;
    start_test();
    applyStimulus(10);
    checkOutput("t1_issue1_cycle", issue_cycle(0), 2);
    checkOutput("t1_issue2_cycle", issue_cycle(1), 4);
    checkOutput("t1_pc_enables", pe_count, 3);
    end_test("t1");

    $display("[TB] LDI");
    load_prog(8'hA2, 8'h7E, 8'hF0, 8'hF0);
    start_test();
    applyStimulus(10);
    checkOutput("t2_first_issue", first_issue, 16'hA27E);
    checkOutput("t2_issue_cycle", issue_cycle(0), 3);
    checkOutput("t2_pc_enables", pe_count, 3);
    end_test("t2");

    $display("[TB] JMP");
    load_prog(8'h80, 8'h40, 8'h00, 8'h00);
    start_test();
    applyStimulus(12);
    checkOutput("t3_jump_addr", jump_addr_seen, 8'h40);
    checkOutput("t3_next_fetch", next_fetch, 8'h40);
    checkOutput("t3_pc_enables", pe_count, 4);
    end_test("t3");

    $display("[TB] JZ not taken / taken");
    load_prog(8'h90, 8'h20, 8'hF0, 8'h00);
    zero_flag = 1'b0;
    start_test();
    applyStimulus(12);
    checkOutput("t4a_next_fetch", next_fetch, 8'h02);
    checkOutput("t4a_pc_enables", pe_count, 4);
    end_test("t4a");
    zero_flag = 1'b1;
    start_test();
    applyStimulus(12);
    checkOutput("t4b_next_fetch", next_fetch, 8'h20);
    end_test("t4b");
    zero_flag = 1'b0;

    $display("[TB] stalls");
    load_prog(8'h13, 8'hA2, 8'h7E, 8'hF0);
    mem_stall = 3;
    ir_stall = 4;
    start_test();
    applyStimulus(45);
    checkOutput("t5_first_transfer", issue_cycle(0), 9);
    checkOutput("t5_issues", issue_cycles.size(), 3);
    checkOutput("t5_pc_enables", pe_count, 4);
    end_test("t5");

    $display("[TB] halt persistence");
    halt_cycles = 0;
    applyStimulus(50);
    checkOutput("t6_halt_cycles", halt_cycles, 50);
    mem_stall = 0;
    ir_stall = 0;
    start_test();
    checkOutput("t6_restart", {mem_read, halted}, 2'b10);
    applyStimulus(40);
    end_test("t6");

    $display("[TB] reset mid-fetch and mid-issue");
    load_prog(8'h80, 8'h40, 8'h00, 8'h00);
    start_test();
    applyStimulus(1);
    start_test();
    applyStimulus(12);
    checkOutput("t7_next_fetch", next_fetch, 8'h40);
    end_test("t7");
    start_test();
    applyStimulus(2);
    start_test();
    applyStimulus(12);
    checkOutput("t8_pc_enables", pe_count, 4);
    end_test("t8");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter WORD_WIDTH, default 8, meaning the width of the PC, memory data and instruction fields.
REQ-002 The module SHALL have port clock, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-004 The module SHALL have port pc, input, WORD_WIDTH, the current result of program_counter.
REQ-005 The module SHALL have port mem_read, output, 1, the instruction-memory read request.
REQ-006 The module SHALL have port mem_address, output, WORD_WIDTH, the read address.
REQ-007 The module SHALL have port mem_data, input, WORD_WIDTH, the read data, valid when mem_ready=1.
REQ-008 The module SHALL have port mem_ready, input, 1, the read-complete strobe.
REQ-009 The module SHALL have port pc_enable, output, 1, which drives program_counter enable.
REQ-010 The module SHALL have ports jump and jz, outputs, 1 each, and jump_address, output, WORD_WIDTH, which drive the like-named program_counter ports.
REQ-011 The module SHALL have ports instr_valid, output, 1; instr_ready, input, 1; opcode, output, 4; reg_sel, output, 4; operand, output, WORD_WIDTH; these form the issue handshake to decode/execute.
REQ-012 The module SHALL have port halted, output, 1, which is high while in state HALT.

Function
REQ-013 The instruction byte format SHALL be [7:4] opcode, [3:0] reg_sel.
REQ-014 Opcodes 4'h8 JMP, 4'h9 JZ and 4'hA LDI SHALL be two-byte instructions whose second byte is the operand; 4'hF HALT and all other opcodes SHALL be one-byte instructions, with operand forced to 0.
REQ-015 The FSM states SHALL be FETCH_OP, FETCH_ARG, ISSUE and HALT.
REQ-016 In FETCH_OP and FETCH_ARG, mem_read SHALL be 1 and mem_address SHALL equal pc combinationally; in ISSUE and HALT, mem_read SHALL be 0.
REQ-017 The FSM SHALL hold FETCH_OP or FETCH_ARG, with pc_enable=0, for any number of cycles while mem_ready=0.
REQ-018 In the cycle where mem_ready=1 during a fetch state, pc_enable SHALL be 1 for exactly that cycle, and mem_data SHALL be captured on that edge.
REQ-019 FETCH_OP with mem_ready=1 SHALL transition to FETCH_ARG if the opcode is two-byte, and to ISSUE otherwise.
REQ-020 FETCH_ARG with mem_ready=1 SHALL latch the operand and transition to ISSUE.
REQ-021 In ISSUE, instr_valid SHALL be 1 and opcode, reg_sel and operand SHALL remain stable until the cycle with instr_ready=1 (the transfer cycle).
REQ-022 In the transfer cycle, ISSUE SHALL transition to HALT if the opcode is HALT, and to FETCH_OP otherwise.
REQ-023 For JMP, the transfer cycle SHALL assert pc_enable=1, jump=1 and jump_address=operand for that single cycle.
REQ-024 For JZ, the transfer cycle SHALL assert pc_enable=1, jz=1 and jump_address=operand; the zero_flag decision belongs to program_counter.
REQ-025 Outside the transfer cycle, jump and jz SHALL be 0 and jump_address SHALL hold the last operand.
REQ-026 instr_valid SHALL never be 1 in FETCH_OP, FETCH_ARG or HALT.
REQ-027 HALT SHALL be absorbing: all strobes 0, halted=1, and only reset exits it.
REQ-028 Latency SHALL be: a one-byte instruction with mem_ready and instr_ready tied high issues every 2 cycles; a two-byte instruction issues every 3 cycles.
REQ-029 mem_data SHALL be ignored whenever mem_ready=0; instr_ready SHALL be ignored outside ISSUE.
REQ-030 If mem_ready=1 and instr_ready=1 arrive together, only the input relevant to the current state SHALL act.

Reset
REQ-031 Reset SHALL be sampled on the rising clock edge and SHALL override all other inputs, including mid-fetch and mid-issue.
REQ-032 After reset the module SHALL be in FETCH_OP with instr_valid=0, pc_enable=0, jump=0, jz=0, halted=0, jump_address=0, opcode=0, reg_sel=0 and operand=0.
REQ-033 A read in flight at reset SHALL be abandoned, and no pc_enable SHALL be generated for it.

Verification
REQ-034 With mem_ready=1, instr_ready=1 and memory [0]=0x13, [1]=0x25: the bench SHALL see instr_valid on cycles 2 and 4 with opcode/reg_sel 1/3 then 2/5, and exactly one pc_enable per byte.
REQ-035 With mem [0]=0xA2, [1]=0x7E: the bench SHALL see a single issue with opcode=A, reg_sel=2, operand=0x7E, and two pc_enable pulses.
REQ-036 With mem [0]=0x80, [1]=0x40: the bench SHALL see jump=1, pc_enable=1 and jump_address=0x40 on one cycle, and the next FETCH_OP address SHALL be 0x40.
REQ-037 With mem [0]=0x90, [1]=0x20: for zero_flag=0 the next address SHALL be 0x02; for zero_flag=1 it SHALL be 0x20.
REQ-038 With mem_ready low for 3 cycles and instr_ready low for 4 cycles: the outputs SHALL stay stable, no extra pc_enable SHALL occur, and no duplicate issue SHALL occur.
REQ-039 With a HALT (0xF0) issued: halted=1 and mem_read=0 SHALL persist for 50 cycles, and after a reset pulse mem_read=1 with halted=0.
